comp_28bit: RTL and testbench



---
 rtl/comp_28bit.sv | 51 +++++
 tb/tb_comp_28bit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/comp_28bit.sv
// comp_28bit: unsigned 28-bit nibble-tree magnitude comparator with registered outputs.
// Define COMP_28BIT_EQ_EN to add the o_equal / o_equal_r ports.
module comp_28bit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [27:0] i_data_a,
  input  logic [27:0] i_data_b,
  output logic        o_less,
  output logic        o_less_r
`ifdef COMP_28BIT_EQ_EN
  ,
  output logic        o_equal,
  output logic        o_equal_r
`endif
);
  logic [6:0] lt_n;
  logic [6:1] eq_n;
  logic lt_65, eq_65, lt_43, eq_43, lt_21, eq_21, lt_hi, eq_hi, lt_lo;
  for (genvar k = 0; k < 7; k++) begin : g_lt
    assign lt_n[k] = i_data_a[4*k +: 4] < i_data_b[4*k +: 4];
  end
  // Nibble 0 equality only matters for the full-equality output
  for (genvar k = 1; k < 7; k++) begin : g_eq
    assign eq_n[k] = i_data_a[4*k +: 4] == i_data_b[4*k +: 4];
  end
  assign lt_65  = lt_n[6] | (eq_n[6] & lt_n[5]);
  assign eq_65  = eq_n[6] & eq_n[5];
  assign lt_43  = lt_n[4] | (eq_n[4] & lt_n[3]);
  assign eq_43  = eq_n[4] & eq_n[3];
  assign lt_21  = lt_n[2] | (eq_n[2] & lt_n[1]);
  assign eq_21  = eq_n[2] & eq_n[1];
  assign lt_hi  = lt_65 | (eq_65 & lt_43);
  assign eq_hi  = eq_65 & eq_43;
  assign lt_lo  = lt_21 | (eq_21 & lt_n[0]);
  assign o_less = lt_hi | (eq_hi & lt_lo);
`ifdef COMP_28BIT_EQ_EN
  assign o_equal = eq_hi & eq_21 & (i_data_a[3:0] == i_data_b[3:0]);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_less_r  <= 1'b0;
      o_equal_r <= 1'b0;
    end else begin
      o_less_r  <= o_less;
      o_equal_r <= o_equal;
    end
`else
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_less_r <= 1'b0;
    else o_less_r <= o_less;
`endif
endmodule

// File: tb/tb_comp_28bit.sv
// tb_comp_28bit: random and directed checks of comp_28bit against an arithmetic model.
module tb_comp_28bit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] a = '0;
  logic [27:0] b = '0;
  logic        less, less_r;
  logic        exp_r = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          rand_pass = 0;
`ifdef COMP_28BIT_EQ_EN
  logic        equal, equal_r;
  logic        exp_eq_r = 1'b0;
`endif

  comp_28bit dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_data_a (a),
    .i_data_b (b),
    .o_less   (less),
    .o_less_r (less_r)
`ifdef COMP_28BIT_EQ_EN
    ,
    .o_equal  (equal),
    .o_equal_r(equal_r)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b (a=%h b=%h t=%0t)", name, got, exp, a, b, $time);
    end
  endtask

  task automatic apply(input logic [27:0] na, input logic [27:0] nb);
    @(posedge clk);
    #1;
    a = na;
    b = nb;
    #1;
  endtask

  // Expected registered values: what the operands compared to at the last edge out of reset
  always @(posedge clk) begin
    exp_r = rst_n ? (a < b) : 1'b0;
`ifdef COMP_28BIT_EQ_EN
    exp_eq_r = rst_n ? (a == b) : 1'b0;
`endif
  end

  always @(negedge clk) begin
    chk("cyc_less", less, a < b);
    chk("cyc_less_r", less_r, exp_r);
`ifdef COMP_28BIT_EQ_EN
    chk("cyc_equal", equal, a == b);
    chk("cyc_equal_r", equal_r, exp_eq_r);
    chk("cyc_exclusive", equal & less, 1'b0);
`endif
  end

  initial begin
    logic [27:0] ra, rb;
    #1;
    chk("reset_less_r", less_r, 1'b0);
    chk("zero_zero", less, 1'b0);
`ifdef COMP_28BIT_EQ_EN
    chk("zero_zero_eq", equal, 1'b1);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    apply(28'h7FFFFFF, 28'h8000000); chk("msb_lt", less, 1'b1);
    apply(28'h8000000, 28'h7FFFFFF); chk("msb_gt", less, 1'b0);
    apply(28'hFFFFFFE, 28'hFFFFFFF); chk("lsb_lt", less, 1'b1);
    apply(28'hFFFFFFF, 28'hFFFFFFE); chk("lsb_gt", less, 1'b0);
    apply(28'hFFFFFFF, 28'hFFFFFFF); chk("max_eq", less, 1'b0);
    apply(28'h0000000, 28'h0000001); chk("a_zero", less, 1'b1);
    apply(28'h1234567, 28'h0000000); chk("b_zero", less, 1'b0);
    apply(28'h0FFFFFF, 28'h1000000); chk("nib_carry", less, 1'b1);
    apply(28'h5A5A5A5, 28'h5A5A5A4); chk("nib0_gt", less, 1'b0);
    apply(28'd5, 28'd9);             chk("five_nine", less, 1'b1);
    @(posedge clk);
    #1;
    chk("five_nine_r", less_r, 1'b1);
    #2;
    rst_n = 1'b0;
    exp_r = 1'b0;
`ifdef COMP_28BIT_EQ_EN
    exp_eq_r = 1'b0;
`endif
    #1;
    chk("async_rst_r", less_r, 1'b0);
    chk("rst_comb_kept", less, 1'b1);
    @(posedge clk);
    #1;
    chk("rst_hold_r", less_r, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_resume_r", less_r, 1'b1);
    for (int i = 0; i < 100; i++) begin
      ra = 28'($urandom_range(0, 28'hFFFFFFF));
      rb = (i % 10 == 0) ? ra : 28'($urandom_range(0, 28'hFFFFFFF));
      if (i % 10 == 5) rb = ra ^ (28'd1 << $urandom_range(0, 27));
      apply(ra, rb);
      checks++;
      if (less === (ra < rb)) rand_pass++;
      else begin
        errors++;
        $display("FAIL rand_less got %b exp %b (a=%h b=%h)", less, ra < rb, ra, rb);
      end
    end
    checks++;
    if (rand_pass != 100) begin
      errors++;
      $display("FAIL rand_pass_count got %0d exp 100", rand_pass);
    end
    @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
